// File: rtl/spi_master_if.sv
// Core-side and SPI-pin signals of the SPI master, grouped for the decode/regfile datapath.
interface spi_master_if #(
  parameter int unsigned W_CPU      = 32,
  parameter int unsigned W_SPI_CTRL = 2
);
  logic [W_SPI_CTRL-1:0] spi_ctrl;
  logic [W_CPU-1:0]      tx_data;
  logic [W_CPU-1:0]      rx_data;
  logic                  stall;
  logic                  done;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    input  spi_ctrl, tx_data, miso,
    output rx_data, stall, done, sclk, mosi, cs_n
  );

  modport slave (
    output spi_ctrl, tx_data, miso,
    input  rx_data, stall, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master executing mtc0/mfc0 frames (MSB first, one slave select); stalls the core
// until the frame completes and returns the received frame for the register-write mux.
module spi_master #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned W_CPU      = 32,
  parameter int unsigned W_SPI_CTRL = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam int unsigned HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [W_SPI_CTRL-1:0] CTRL_MOSI = W_SPI_CTRL'(1);
  localparam logic [W_SPI_CTRL-1:0] CTRL_MISO = W_SPI_CTRL'(2);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, DONE} state_t;

  state_t             state_q, state_d;
  logic [HC_W-1:0]    hc_q, hc_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [DATA_W-1:0]  rxsh_q, rxsh_d;
  logic [W_CPU-1:0]   rx_q, rx_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               done_q, done_d;

  logic               cmd_valid;
  logic               hc_last;
  logic [DATA_W-1:0]  tx_sel;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  rx_shift;
  logic               unused_tx;

  // Codes other than MOSI/MISO behave as NOP
  assign cmd_valid = (bus.spi_ctrl == CTRL_MOSI) || (bus.spi_ctrl == CTRL_MISO);
  assign unused_tx = ^bus.tx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hc_q    <= '0;
      bc_q    <= '0;
      shreg_q <= '0;
      rxsh_q  <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bc_q    <= bc_d;
      shreg_q <= shreg_d;
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    bc_d     = bc_q;
    shreg_d  = shreg_q;
    rxsh_d   = rxsh_q;
    rx_d     = rx_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    done_d   = 1'b0;
    hc_last  = (hc_q == HC_W'(CLK_DIV - 1));
    tx_sel   = (bus.spi_ctrl == CTRL_MOSI) ? bus.tx_data[DATA_W-1:0] : '0;
    shifted  = shreg_q << 1;
    rx_shift = DATA_W'({rxsh_q, bus.miso});

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          shreg_d = tx_sel;
          mosi_d  = tx_sel[DATA_W-1];
          cs_n_d  = 1'b0;
          bc_d    = '0;
          hc_d    = '0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (hc_last) begin
          hc_d    = '0;
          sclk_d  = 1'b1;
          rxsh_d  = rx_shift;
          state_d = HIGH;
        end else begin
          hc_d = HC_W'(hc_q + 1'b1);
        end
      end
      HIGH: begin
        if (hc_last) begin
          hc_d    = '0;
          sclk_d  = 1'b0;
          shreg_d = shifted;
          mosi_d  = shifted[DATA_W-1];
          state_d = LOW;
        end else begin
          hc_d = HC_W'(hc_q + 1'b1);
        end
      end
      LOW: begin
        if (hc_last) begin
          hc_d = '0;
          if (bc_q == BC_W'(DATA_W - 1)) begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            rx_d    = W_CPU'(rxsh_q);
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            bc_d    = BC_W'(bc_q + 1'b1);
            sclk_d  = 1'b1;
            rxsh_d  = rx_shift;
            state_d = HIGH;
          end
        end else begin
          hc_d = HC_W'(hc_q + 1'b1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall covers the accept cycle and the whole frame, but drops in DONE so the core retires
  assign bus.stall   = !rst && (((state_q == IDLE) && cmd_valid) || (state_q == LEAD) ||
                                (state_q == HIGH) || (state_q == LOW));
  assign bus.rx_data = rx_q;
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: an 8-bit/div-2 instance with a mode-0 slave and a 32-bit/div-1 loopback.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_master_if #(.W_CPU(32), .W_SPI_CTRL(2)) if0();
  spi_master_if #(.W_CPU(32), .W_SPI_CTRL(2)) if1();

  spi_master #(.DATA_W(8),  .CLK_DIV(2), .W_CPU(32), .W_SPI_CTRL(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  spi_master #(.DATA_W(32), .CLK_DIV(1), .W_CPU(32), .W_SPI_CTRL(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  // Mode-0 slave on instance 0: next bit presented after each SCLK fall, MSB first
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] sb_sh;
  int         fall_cnt = 0;
  always @(negedge if0.sclk or posedge if0.cs_n) begin
    if (if0.cs_n) fall_cnt = 0;
    else          fall_cnt = fall_cnt + 1;
  end
  assign sb_sh    = slave_byte << fall_cnt;
  assign if0.miso = (!if0.cs_n && fall_cnt < 8) ? sb_sh[7] : 1'b0;
  assign if1.miso = if1.mosi;

  // Bits seen on the wire at each SCLK rise
  logic [7:0]  cap0 = 8'h00;
  logic [31:0] cap1 = 32'h0;
  always @(posedge if0.sclk) cap0 = {cap0[6:0], if0.mosi};
  always @(posedge if1.sclk) cap1 = {cap1[30:0], if1.mosi};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected pins at s cycles after command accept, from the frame timing rules
  task automatic model_at(input int s, input int w, input int d, input logic [31:0] txf,
                          output logic e_st, output logic e_cs, output logic e_sc,
                          output logic e_mo, output logic e_dn);
    int l, p, i, j;
    l    = 1 + (2 * w + 1) * d;
    e_st = (s <= l - 1);
    e_cs = !(s >= 1 && s <= l - 1);
    e_dn = (s == l);
    e_sc = 1'b0;
    e_mo = 1'b0;
    if (s >= 1 && s <= d) begin
      e_mo = 1'(txf >> (w - 1));
    end else if (s > d && s < l) begin
      p    = s - 1 - d;
      i    = p / (2 * d);
      e_sc = (p % (2 * d)) < d;
      j    = e_sc ? i : i + 1;
      if (j < w) e_mo = 1'(txf >> (w - 1 - j));
    end
  endtask

  logic        m_act [2] = '{1'b0, 1'b0};
  int          m_t0  [2] = '{0, 0};
  logic [31:0] m_txf [2] = '{32'h0, 32'h0};
  logic [31:0] m_rxf [2] = '{32'h0, 32'h0};
  logic [31:0] m_rxh [2] = '{32'h0, 32'h0};
  int          stall_cnt [2] = '{0, 0};
  int          done_cnt  [2] = '{0, 0};
  int          frame_cnt [2] = '{0, 0};
  logic        prev_cs   [2] = '{1'b1, 1'b1};

  task automatic check_one(input int id, input logic [1:0] ctrl, input logic [31:0] tx,
                           input logic st, input logic cs, input logic sc, input logic mo,
                           input logic dn, input logic [31:0] rx);
    int w, d, l;
    logic e_st, e_cs, e_sc, e_mo, e_dn;
    w = (id == 1) ? 32 : 8;
    d = (id == 1) ? 1 : 2;
    l = 1 + (2 * w + 1) * d;
    if (rst) begin
      m_act[id] = 1'b0;
      m_rxh[id] = 32'h0;
    end else begin
      if (m_act[id] && (ncyc - m_t0[id]) > l) m_act[id] = 1'b0;
      if (!m_act[id] && (ctrl == 2'd1 || ctrl == 2'd2)) begin
        m_act[id] = 1'b1;
        m_t0[id]  = ncyc;
        m_txf[id] = (ctrl == 2'd1) ? ((id == 1) ? tx : (tx & 32'hFF)) : 32'h0;
        m_rxf[id] = (id == 1) ? m_txf[id] : 32'(slave_byte);
      end
    end
    if (m_act[id]) begin
      model_at(ncyc - m_t0[id], w, d, m_txf[id], e_st, e_cs, e_sc, e_mo, e_dn);
      if (ncyc - m_t0[id] == l) m_rxh[id] = m_rxf[id];
    end else begin
      e_st = 1'b0; e_cs = 1'b1; e_sc = 1'b0; e_mo = 1'b0; e_dn = 1'b0;
    end
    chk($sformatf("d%0d_stall", id), 32'(st), 32'(e_st));
    chk($sformatf("d%0d_cs_n", id),  32'(cs), 32'(e_cs));
    chk($sformatf("d%0d_sclk", id),  32'(sc), 32'(e_sc));
    chk($sformatf("d%0d_mosi", id),  32'(mo), 32'(e_mo));
    chk($sformatf("d%0d_done", id),  32'(dn), 32'(e_dn));
    chk($sformatf("d%0d_rx", id),    rx, m_rxh[id]);
    if (st) stall_cnt[id]++;
    if (dn) done_cnt[id]++;
    if (prev_cs[id] && !cs) frame_cnt[id]++;
    prev_cs[id] = cs;
  endtask

  always @(negedge clk) begin
    ncyc++;
    check_one(0, if0.spi_ctrl, if0.tx_data, if0.stall, if0.cs_n, if0.sclk, if0.mosi, if0.done, if0.rx_data);
    check_one(1, if1.spi_ctrl, if1.tx_data, if1.stall, if1.cs_n, if1.sclk, if1.mosi, if1.done, if1.rx_data);
  end

  task automatic wait_done(input int id);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ((id == 0 && if0.done) || (id == 1 && if1.done)) return;
    end
    chk($sformatf("d%0d_done_timeout", id), 32'h0, 32'h1);
  endtask

  // One instruction: command held until the done pulse, then the core moves on
  task automatic frame(input int id, input logic [1:0] ctrl, input logic [31:0] tx);
    stall_cnt[id] = 0;
    @(posedge clk); #1;
    if (id == 0) begin if0.spi_ctrl = ctrl; if0.tx_data = tx; end
    else         begin if1.spi_ctrl = ctrl; if1.tx_data = tx; end
    wait_done(id);
    @(posedge clk); #1;
    if (id == 0) if0.spi_ctrl = 2'd0;
    else         if1.spi_ctrl = 2'd0;
  endtask

  int f0, d0;

  initial begin
    if0.spi_ctrl = 2'd0; if0.tx_data = 32'h0;
    if1.spi_ctrl = 2'd0; if1.tx_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rx", if0.rx_data, 32'h0);
    chk("reset_cs_n", 32'(if0.cs_n), 32'h1);
    chk("reset_done", 32'(if0.done), 32'h0);

    // NOP with noisy tx_data: nothing happens
    if0.tx_data = 32'hFFFFFFFF;
    repeat (20) @(posedge clk);
    chk("nop_frames", 32'(frame_cnt[0]), 32'h0);

    // MOSI 0xA5 while the slave returns 0x96
    slave_byte = 8'h96;
    frame(0, 2'd1, 32'h000000A5);
    chk("mosi_wire_bits", 32'(cap0), 32'hA5);
    chk("mosi_stall_len", 32'(stall_cnt[0]), 32'd35);
    chk("mosi_rx", if0.rx_data, 32'h96);
    @(negedge clk);
    chk("done_one_cycle", 32'(if0.done), 32'h0);

    // MISO: wire carries zeros, slave sends 0x3C
    slave_byte = 8'h3C;
    frame(0, 2'd2, 32'h0000FFFF);
    chk("miso_wire_bits", 32'(cap0), 32'h00);
    chk("miso_rx", if0.rx_data, 32'h3C);
    repeat (5) @(negedge clk);
    chk("miso_rx_held", if0.rx_data, 32'h3C);

    // Same command held across DONE: one new frame per accept
    slave_byte = 8'h81;
    f0 = frame_cnt[0];
    d0 = done_cnt[0];
    @(posedge clk); #1;
    if0.spi_ctrl = 2'd1; if0.tx_data = 32'hFFFF005A;
    wait_done(0);
    wait_done(0);
    @(posedge clk); #1;
    if0.spi_ctrl = 2'd0;
    repeat (40) @(negedge clk);
    chk("held_frames", 32'(frame_cnt[0] - f0), 32'd2);
    chk("held_dones", 32'(done_cnt[0] - d0), 32'd2);
    chk("held_wire_bits", 32'(cap0), 32'h5A);
    chk("held_rx", if0.rx_data, 32'h81);

    // Reset in the middle of a HIGH phase
    slave_byte = 8'hE7;
    @(posedge clk); #1;
    if0.spi_ctrl = 2'd1; if0.tx_data = 32'h000000C3;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (if0.sclk) break;
    end
    chk("abort_pre_sclk", 32'(if0.sclk), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    if0.spi_ctrl = 2'd0;
    #1;
    chk("abort_cs_n", 32'(if0.cs_n), 32'h1);
    chk("abort_sclk", 32'(if0.sclk), 32'h0);
    chk("abort_stall", 32'(if0.stall), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d0 = done_cnt[0];
    repeat (40) @(negedge clk);
    chk("abort_rx", if0.rx_data, 32'h0);
    chk("abort_no_done", 32'(done_cnt[0] - d0), 32'h0);

    // 32-bit loopback at CLK_DIV=1
    frame(1, 2'd2, 32'h12345678);
    chk("loop_miso_rx", if1.rx_data, 32'h0);
    frame(1, 2'd1, 32'hDEADBEEF);
    chk("loop_rx", if1.rx_data, 32'hDEADBEEF);
    chk("loop_wire_bits", cap1, 32'hDEADBEEF);
    chk("loop_stall_len", 32'(stall_cnt[1]), 32'd66);

    // Illegal control code behaves as NOP
    f0 = frame_cnt[0] + frame_cnt[1];
    stall_cnt[0] = 0;
    stall_cnt[1] = 0;
    @(posedge clk); #1;
    if0.spi_ctrl = 2'd3; if1.spi_ctrl = 2'd3;
    repeat (20) @(negedge clk);
    chk("illegal_frames", 32'(frame_cnt[0] + frame_cnt[1] - f0), 32'h0);
    chk("illegal_stall", 32'(stall_cnt[0] + stall_cnt[1]), 32'h0);
    chk("illegal_rx0", if0.rx_data, 32'h0);
    chk("illegal_rx1", if1.rx_data, 32'hDEADBEEF);
    if0.spi_ctrl = 2'd0; if1.spi_ctrl = 2'd0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
